// File: rtl/tanh_approx_if.sv
// Activation unit port bundle.
// Sample in, registered result out.
interface tanh_approx_if;
  logic        in_valid;
  logic [16:0] x;
  logic        out_valid;
  logic [15:0] f;

  modport master (
    output in_valid,
    output x,
    input  out_valid,
    input  f
  );

  modport slave (
    input  in_valid,
    input  x,
    output out_valid,
    output f
  );
endinterface

// File: rtl/tanh_approx.sv
// Piecewise-linear tanh, 8 segments,
// odd-symmetric, one register stage.
module tanh_approx (
  input  logic         clk,
  input  logic         reset,
  tanh_approx_if.slave io
);

  function automatic logic [15:0] ytab(
    input logic [3:0] k
  );
    unique case (k)
      4'd0:    ytab = 16'd0;
      4'd1:    ytab = 16'd8025;
      4'd2:    ytab = 16'd15143;
      4'd3:    ytab = 16'd20813;
      4'd4:    ytab = 16'd24956;
      4'd5:    ytab = 16'd27797;
      4'd6:    ytab = 16'd29660;
      4'd7:    ytab = 16'd30847;
      default: ytab = 16'd31589;
    endcase
  endfunction

  logic [16:0] a;
  logic [3:0]  k;
  logic [12:0] frac;
  logic [15:0] y0;
  logic [15:0] y1;
  logic [15:0] dy;
  logic [25:0] prod;
  logic [15:0] m;
  logic [15:0] g;

  logic [15:0] f_d;
  logic [15:0] f_q;
  logic        out_valid_d;
  logic        out_valid_q;

  // Magnitude, segment lookup, interpolation and sign.
  always_comb begin
    a    = io.x[16] ? (~io.x + 17'd1) : io.x;
    k    = a[16:13];
    frac = a[12:0];
    y0   = ytab(k);
    y1   = ytab(4'(k + 4'd1));
    dy   = y1 - y0;
    prod = dy[12:0] * frac;
    m    = y0 + 16'(prod >> 13);
    g    = io.x[16] ? (~m + 16'd1) : m;
  end

  // Capture on valid, hold otherwise.
  always_comb begin
    f_d         = f_q;
    out_valid_d = io.in_valid;
    if (io.in_valid) begin
      f_d = g;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q         <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.f         = f_q;
  assign io.out_valid = out_valid_q;

endmodule

// File: tb/tb_tanh_approx.sv
// Scoreboard bench for tanh_approx.
// Random plus directed stimulus.
module tb_tanh_approx;

  logic clk;
  logic reset;
  tanh_approx_if io ();

  tanh_approx dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [15:0] f;
    logic [16:0] x;
    logic        chk_acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_f = 16'd0;

  int ytab[9] = '{0, 8025, 15143, 20813,
    24956, 27797, 29660, 30847, 31589};

  function automatic int model(input logic [16:0] x);
    int xv;
    int av;
    int k;
    int fr;
    int mv;
    xv = int'(signed'(x));
    av = (xv < 0) ? -xv : xv;
    if (av >= 65536) begin
      mv = ytab[8];
    end else begin
      k  = av / 8192;
      fr = av % 8192;
      mv = ytab[k] + ((ytab[k+1] - ytab[k]) * fr) / 8192;
    end
    return (xv < 0) ? -mv : mv;
  endfunction

  task automatic step(
    input logic        rst,
    input logic        v,
    input logic [16:0] xx
  );
    exp_t e;
    @(negedge clk);
    reset       = rst;
    io.in_valid = v;
    io.x        = xx;
    if (rst) begin
      exp_f = 16'd0;
      e.ov  = 1'b0;
    end else if (v) begin
      exp_f = 16'(model(xx));
      e.ov  = 1'b1;
    end else begin
      e.ov  = 1'b0;
    end
    e.f       = exp_f;
    e.x       = xx;
    e.chk_acc = v && !rst;
    q.push_back(e);
  endtask

  task automatic expect_f(
    input logic [16:0] xx,
    input logic [15:0] want
  );
    checks++;
    if (16'(model(xx)) !== want) begin
      errors++;
      $display("FAIL model x=%h got=%h want=%h",
        xx, 16'(model(xx)), want);
    end
    step(1'b0, 1'b1, xx);
  endtask

  // Monitor: compare every cycle's registered outputs.
  initial begin
    exp_t e;
    real  ref_v;
    real  d;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (io.out_valid !== e.ov || io.f !== e.f) begin
          errors++;
          $display("FAIL out x=%h got ov=%b f=%h want ov=%b f=%h",
            e.x, io.out_valid, io.f, e.ov, e.f);
        end
        if (e.chk_acc) begin
          ref_v = 32768.0 *
            $tanh(real'(int'(signed'(e.x))) / 32768.0);
          d = real'(int'(signed'(io.f))) - ref_v;
          if (d < 0.0) d = -d;
          if (d > 400.0) begin
            errors++;
            $display("FAIL accuracy x=%h got=%h err=%f",
              e.x, io.f, d);
          end
        end
      end
    end
  end

  initial begin
    logic [16:0] rx;
    reset       = 1'b1;
    io.in_valid = 1'b0;
    io.x        = 17'd0;

    step(1'b1, 1'b1, 17'h08000);
    step(1'b1, 1'b1, 17'h08000);
    step(1'b0, 1'b1, 17'h08000);

    expect_f(17'h00000, 16'h0000);
    expect_f(17'h02000, 16'h1F59);
    expect_f(17'h08000, 16'h617C);
    expect_f(17'h0FFFF, 16'h7B64);
    expect_f(17'h01000, 16'h0FAC);
    expect_f(17'h05000, 16'h463A);
    expect_f(17'h18000, 16'h9E84);
    expect_f(17'h10000, 16'h849B);
    expect_f(17'h1F000, 16'hF054);

    step(1'b0, 1'b1, 17'h02000);
    step(1'b0, 1'b1, 17'h04000);
    step(1'b0, 1'b1, 17'h06000);
    step(1'b0, 1'b0, 17'h0ABCD);
    step(1'b0, 1'b0, 17'h01234);

    step(1'b0, 1'b1, 17'h0C000);
    step(1'b1, 1'b1, 17'h0C000);
    step(1'b0, 1'b0, 17'h03000);
    step(1'b0, 1'b1, 17'h03000);

    for (int i = 0; i < 4000; i++) begin
      rx = 17'($urandom);
      step(1'b0, ($urandom_range(0, 7) != 0), rx);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 17'(i * 8192));
      step(1'b0, 1'b1, 17'(i * 8192 + 8191));
      step(1'b0, 1'b1, 17'(-(i * 8192 + 8191)));
    end

    step(1'b0, 1'b0, 17'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/tanh_approx.md
Name: tanh_approx

Overview:
- Registered, piecewise-linear hyperbolic-tangent activation unit for the reservoir (echo-state) network neuron datapath.
- Each neuron instantiates one copy. It maps a 17-bit signed pre-activation sum to a 16-bit signed neuron state.
- Uses an 8-segment endpoint table with linear interpolation and exact odd symmetry.

Parameters:
- none. The fixed-point formats and table below are fixed for this block.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies x for the current cycle.
- x  input  17  signed two's complement, Q2.15 (range -2.0 to +2.0-2^-15).
- out_valid  output  1  registered copy of in_valid.
- f  output  16  signed two's complement, Q1.15, approximately tanh(x).

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset: on a clk edge with reset=1, f<=0 and out_valid<=0. reset has priority over in_valid.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge n, then f equals g(x) and out_valid=1 after edge n.
  - If in_valid=0 at an edge, f holds its previous value and out_valid<=0.
- Magnitude: a = |x| as 17-bit unsigned Q2.15.
  - x = 0x10000 (-2.0) gives a = 0x10000 (2.0). No overflow.
- Segment select: k = a[16:13], range 0..8. frac = a[12:0], 13 bits, weight 2^-15 per LSB.
- Endpoint table Y[k] = round(tanh(0.25*k)*32768):
  - Y0=0, Y1=8025, Y2=15143, Y3=20813, Y4=24956
  - Y5=27797, Y6=29660, Y7=30847, Y8=31589
- Magnitude result, for k<8:
  - m = Y[k] + floor((Y[k+1]-Y[k]) * frac / 8192).
  - The product is unsigned, at most 13x13 bits. Truncation is floor, with no rounding.
- For k=8 (only a=0x10000): m = Y8 = 31589.
- m is at most 31589, so no saturation logic is required. m is monotonic non-decreasing in a.
- Sign: f = m if x[16]=0, else f = -m (two's complement, 16 bits).
  - Gives exact odd symmetry: g(-x) = -g(x) for every x except -2.0, which has no positive counterpart.
- x=0 gives f=0. There is no negative-zero case.
- Back-to-back: a new in_valid sample every cycle is accepted. There is no stall or backpressure.
- Reset asserted mid-stream discards the pending result. The first valid output after reset deassertion appears one cycle after the first in_valid=1 sample.
- The table is a constant case or ROM. It does not depend on initial blocks.
- Combinational depth: one 13x13 multiply, one add, one negate. Pipelining beyond 1 register stage is not permitted; latency is fixed at 1.

Test Plan:
- Reset: reset=1 for 2 edges while in_valid=1, x=0x08000 -> f=0x0000, out_valid=0. Release reset -> next edge f=0x617C (24956), out_valid=1.
- Endpoints:
  - x=0x00000 -> f=0x0000
  - x=0x02000 -> 0x1F59
  - x=0x08000 -> 0x617C
  - x=0x0FFFF -> 0x7B64 (k=7, frac=8191, 30847+741)
- Interpolation: x=0x01000 (0.125) -> f=0x0FAC (4012). x=0x05000 (0.625) -> 15143+floor(5670*4096/8192) = 17978 = 0x463A.
- Negative and symmetry:
  - x=0x18000 (-1.0) -> f=0x9E84 (-24956)
  - x=0x10000 (-2.0) -> 0x849B (-31589)
  - x=0x1F000 (-0.125) -> 0xF054 (-4012)
- Handshake: stream x=0x02000, 0x04000, 0x06000 on 3 consecutive cycles with in_valid=1, then in_valid=0 -> f sequence 8025, 15143, 20813. After that, f holds 20813 and out_valid drops to 0.
- Sweep: all 2^17 inputs with in_valid=1 -> f matches the bit-exact reference model. |f - 32768*tanh(x)| <= 400 LSB. m is monotonic in |x|.
